// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master drives operands and out_ready; slave is the adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage, with a
// single global stall (en) shared by all stages and valid/ready flow control.
module pipelined_adder_stage #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             prv_vld,
    input  logic [WIDTH-1:0] prv_a,
    input  logic [WIDTH-1:0] prv_b,
    input  logic [WIDTH-1:0] prv_sum,
    input  logic             prv_c,
    input  logic             prv_am,
    input  logic             prv_bm,
    output logic             vld_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] sum_q,
    output logic             c_q,
    output logic             am_q,
    output logic             bm_q
);
    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] sum_d;
    logic             unused_low;

    // Operands arrive pre-shifted so the live chunk always sits in the low bits.
    assign part = {1'b0, prv_a[CHUNK-1:0]} + {1'b0, prv_b[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, prv_c};

    // Low sum bits are placeholders that get shifted out as chunks are appended.
    assign unused_low = ^prv_sum[CHUNK-1:0];

    // New chunk enters at the top and older chunks slide down; after STAGES
    // insertions chunk 0 lands at bit 0.
    generate
        if (CHUNK < WIDTH) begin : g_ins
            assign sum_d = {part[CHUNK-1:0], prv_sum[WIDTH-1:CHUNK]};
        end else begin : g_full
            assign sum_d = part[CHUNK-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
            am_q  <= 1'b0;
            bm_q  <= 1'b0;
        end else if (en) begin
            vld_q <= prv_vld;
            a_q   <= prv_a >> CHUNK;
            b_q   <= prv_b >> CHUNK;
            sum_q <= sum_d;
            c_q   <= part[CHUNK];
            am_q  <= prv_am;
            bm_q  <= prv_bm;
        end
    end
endmodule

module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_adder_if.slave   bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic                          en;
    logic [WIDTH-1:0]              b_eff;
    logic [STAGES:0]               vld_pipe;
    logic [STAGES:0][WIDTH-1:0]    a_pipe;
    logic [STAGES:0][WIDTH-1:0]    b_pipe;
    logic [STAGES:0][WIDTH-1:0]    sum_pipe;
    logic [STAGES:0]               c_pipe;
    logic [STAGES:0]               am_pipe;
    logic [STAGES:0]               bm_pipe;
    logic                          unused_tail;

    // Whole pipe advances together; a full pipe drains through a stalled sink
    // only when out_ready frees the last slot.
    assign en           = ~vld_pipe[STAGES] | bus.out_ready;
    assign bus.in_ready = en;

    assign b_eff       = bus.sub ? ~bus.b : bus.b;
    assign vld_pipe[0] = bus.in_valid;
    assign a_pipe[0]   = bus.a;
    assign b_pipe[0]   = b_eff;
    assign sum_pipe[0] = '0;
    assign c_pipe[0]   = bus.sub | bus.cin;
    assign am_pipe[0]  = bus.a[WIDTH-1];
    assign bm_pipe[0]  = b_eff[WIDTH-1];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            pipelined_adder_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .prv_vld (vld_pipe[k]),
                .prv_a   (a_pipe[k]),
                .prv_b   (b_pipe[k]),
                .prv_sum (sum_pipe[k]),
                .prv_c   (c_pipe[k]),
                .prv_am  (am_pipe[k]),
                .prv_bm  (bm_pipe[k]),
                .vld_q   (vld_pipe[k+1]),
                .a_q     (a_pipe[k+1]),
                .b_q     (b_pipe[k+1]),
                .sum_q   (sum_pipe[k+1]),
                .c_q     (c_pipe[k+1]),
                .am_q    (am_pipe[k+1]),
                .bm_q    (bm_pipe[k+1])
            );
        end
    endgenerate

    // Operand bits are fully consumed by the last stage.
    assign unused_tail = ^{a_pipe[STAGES], b_pipe[STAGES]};

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.s         = sum_pipe[STAGES];
    assign bus.cout      = c_pipe[STAGES];
    assign bus.ovf       = (am_pipe[STAGES] == bm_pipe[STAGES]) &
                           (sum_pipe[STAGES][WIDTH-1] != am_pipe[STAGES]);
endmodule
